// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: steps each instruction through fetch/decode/execute/memory/writeback.
// Latency: 3 cycles (branch/jal/jalr), 4 (R/I/store), 5 (load) with no memory wait states.
// Backpressure: FETCH, MEM_RD and MEM_WR hold while mem_ready is low (when MEM_WAIT=1); strobes stay asserted.
module multicycle_control #(
    parameter logic        MEM_WAIT = 1'b1,
    parameter logic        EN_JALR  = 1'b1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_MEM, WB_ALU, BRANCH, JAL, JALR, TRAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic             rdy;
    logic             retire;

    // Without the wait handshake the memory is assumed to answer every cycle.
    assign rdy = (MEM_WAIT == 1'b0) | mem_ready;

    // An instruction retires on the step that returns the FSM to FETCH; TRAP never retires.
    assign retire = (state == WB_ALU) || (state == WB_MEM) || (state == BRANCH) ||
                    (state == JAL) || (state == JALR) || ((state == MEM_WR) && rdy);

    // State sequencing and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            cnt_q <= '0;
        end else begin
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
            case (state)
                FETCH:    if (rdy) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_R:               state <= EXEC_R;
                        OP_I:               state <= EXEC_I;
                        OP_LOAD, OP_STORE:  state <= MEM_ADDR;
                        OP_BRANCH:          state <= BRANCH;
                        OP_JAL:             state <= JAL;
                        OP_JALR:            state <= EN_JALR ? JALR : TRAP;
                        default:            state <= TRAP;
                    endcase
                end
                EXEC_R, EXEC_I:  state <= WB_ALU;
                // IR is stable here, so the opcode is simply looked at again.
                MEM_ADDR: state <= (opcode == OP_STORE) ? MEM_WR : MEM_RD;
                MEM_RD:   if (rdy) state <= WB_MEM;
                MEM_WR:   if (rdy) state <= FETCH;
                WB_ALU, WB_MEM, BRANCH, JAL, JALR: state <= FETCH;
                TRAP:     state <= TRAP;
                default:  state <= TRAP;
            endcase
        end
    end

    // Datapath controls decoded from the state (plus the memory handshake in FETCH); all zero during reset.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        instret    = cnt_q;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
            end
            DECODE:   alu_src_b = 2'b10;
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            WB_ALU:   reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
            // PC already holds old-PC+4, which is the link value.
            JAL: begin
                pc_write   = 1'b1;
                pc_src     = 2'b01;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
            end
            JALR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
            end
            TRAP:     illegal = 1'b1;
            default:  illegal = 1'b1;
        endcase
        if (reset) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            pc_src     = 2'b00;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            mem_to_reg = 2'b00;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            illegal    = 1'b0;
            instret    = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b1;
    int         sel = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // u0: defaults; u1: no wait handshake, no jalr, 4-bit counter; u2: waits enabled, 4-bit counter.
    logic pcw0, br0, iod0, mr0, mw0, irw0, rw0, a0, ill0;
    logic [1:0] pcs0, m2r0, b0, op0;
    logic [31:0] cnt0;
    logic pcw1, br1, iod1, mr1, mw1, irw1, rw1, a1, ill1;
    logic [1:0] pcs1, m2r1, b1, op1;
    logic [3:0] cnt1;
    logic pcw2, br2, iod2, mr2, mw2, irw2, rw2, a2, ill2;
    logic [1:0] pcs2, m2r2, b2, op2;
    logic [3:0] cnt2;

    multicycle_control u0 (
        .clk(clk), .reset(rst[0]), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw0), .branch(br0), .pc_src(pcs0), .i_or_d(iod0), .mem_read(mr0),
        .mem_write(mw0), .ir_write(irw0), .mem_to_reg(m2r0), .reg_write(rw0),
        .alu_src_a(a0), .alu_src_b(b0), .alu_op(op0), .illegal(ill0), .instret(cnt0)
    );

    multicycle_control #(.MEM_WAIT(1'b0), .EN_JALR(1'b0), .CNT_W(4)) u1 (
        .clk(clk), .reset(rst[1]), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw1), .branch(br1), .pc_src(pcs1), .i_or_d(iod1), .mem_read(mr1),
        .mem_write(mw1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_write(rw1),
        .alu_src_a(a1), .alu_src_b(b1), .alu_op(op1), .illegal(ill1), .instret(cnt1)
    );

    multicycle_control #(.MEM_WAIT(1'b1), .EN_JALR(1'b1), .CNT_W(4)) u2 (
        .clk(clk), .reset(rst[2]), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw2), .branch(br2), .pc_src(pcs2), .i_or_d(iod2), .mem_read(mr2),
        .mem_write(mw2), .ir_write(irw2), .mem_to_reg(m2r2), .reg_write(rw2),
        .alu_src_a(a2), .alu_src_b(b2), .alu_op(op2), .illegal(ill2), .instret(cnt2)
    );

    // Control word layout: {pc_write, branch, pc_src, i_or_d, mem_read, mem_write, ir_write,
    //                       mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal}
    logic [16:0] ctl_s;
    logic [31:0] cnt_s;
    always_comb begin
        ctl_s = {pcw0, br0, pcs0, iod0, mr0, mw0, irw0, m2r0, rw0, a0, b0, op0, ill0};
        cnt_s = cnt0;
        if (sel == 1) begin
            ctl_s = {pcw1, br1, pcs1, iod1, mr1, mw1, irw1, m2r1, rw1, a1, b1, op1, ill1};
            cnt_s = {28'd0, cnt1};
        end else if (sel == 2) begin
            ctl_s = {pcw2, br2, pcs2, iod2, mr2, mw2, irw2, m2r2, rw2, a2, b2, op2, ill2};
            cnt_s = {28'd0, cnt2};
        end
    end

    function automatic logic [16:0] mk(input logic pcw, input logic br, input logic [1:0] pcs,
                                       input logic iod, input logic mr, input logic mw,
                                       input logic irw, input logic [1:0] m2r, input logic rw,
                                       input logic a, input logic [1:0] b, input logic [1:0] op,
                                       input logic ill);
        return {pcw, br, pcs, iod, mr, mw, irw, m2r, rw, a, b, op, ill};
    endfunction

    logic [16:0] W_FET, W_FETW, W_DEC, W_EXR, W_EXI, W_WBA, W_MA, W_MRD, W_WBM, W_MWR;
    logic [16:0] W_BR, W_JAL, W_JALR, W_TRAP, W_ZERO;

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic [16:0] exp_ctl;
        logic [31:0] exp_cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic [6:0] op, input logic rdy, input logic [16:0] w, input int cnt);
        vec_t v;
        v.op = op; v.rdy = rdy; v.exp_ctl = w; v.exp_cnt = 32'(cnt);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [16:0] exp_ctl, input logic [31:0] exp_cnt);
        checks++;
        if (ctl_s !== exp_ctl || cnt_s !== exp_cnt) begin
            errors++;
            $display("FAIL %s: ctl=%b instret=%0d, expected ctl=%b instret=%0d",
                     name, ctl_s, cnt_s, exp_ctl, exp_cnt);
        end
    endtask

    // One clock cycle on the selected unit: drive inputs at the falling edge, check just after.
    task automatic cyc(input logic [6:0] op, input logic rdy, input logic [16:0] w, input int cnt,
                       input string name);
        @(negedge clk);
        rst[sel] = 1'b0;
        opcode = op;
        mem_ready = rdy;
        #1;
        check(name, w, 32'(cnt));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst[sel] = 1'b1;
        #1;
        check({name, "_asserted"}, W_ZERO, 32'd0);
        @(negedge clk);
        #1;
        check({name, "_held"}, W_ZERO, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int mw_cycles;
        W_FET  = mk(1, 0, 2'b00, 0, 1, 0, 1, 2'b00, 0, 0, 2'b01, 2'b00, 0);
        W_FETW = mk(0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 0, 2'b01, 2'b00, 0);
        W_DEC  = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b10, 2'b00, 0);
        W_EXR  = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b10, 0);
        W_EXI  = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 2'b11, 0);
        W_WBA  = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 2'b00, 0);
        W_MA   = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 2'b00, 0);
        W_MRD  = mk(0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        W_WBM  = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00, 0);
        W_MWR  = mk(0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        W_BR   = mk(0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b01, 0);
        W_JAL  = mk(1, 0, 2'b01, 0, 0, 0, 0, 2'b10, 1, 0, 2'b00, 2'b00, 0);
        W_JALR = mk(1, 0, 2'b10, 0, 0, 0, 0, 2'b10, 1, 1, 2'b10, 2'b00, 0);
        W_TRAP = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1);
        W_ZERO = '0;

        // R-type, I-type: 4 cycles each.
        add(OP_R, 1, W_FET, 0);   add(OP_R, 0, W_DEC, 0);   add(OP_R, 1, W_EXR, 0);   add(OP_R, 1, W_WBA, 0);
        add(OP_I, 1, W_FET, 1);   add(OP_I, 1, W_DEC, 1);   add(OP_I, 0, W_EXI, 1);   add(OP_I, 1, W_WBA, 1);
        // Load with two wait cycles in MEM_RD: 7 cycles.
        add(OP_LOAD, 1, W_FET, 2); add(OP_LOAD, 1, W_DEC, 2); add(OP_LOAD, 1, W_MA, 2);
        add(OP_LOAD, 0, W_MRD, 2); add(OP_LOAD, 0, W_MRD, 2); add(OP_LOAD, 1, W_MRD, 2);
        add(OP_LOAD, 1, W_WBM, 2);
        // Store with one fetch wait and one write wait.
        add(OP_STORE, 0, W_FETW, 3); add(OP_STORE, 1, W_FET, 3); add(OP_STORE, 1, W_DEC, 3);
        add(OP_STORE, 1, W_MA, 3);   add(OP_STORE, 0, W_MWR, 3); add(OP_STORE, 1, W_MWR, 3);
        // Branch, jal, jalr back to back: 3 cycles each.
        add(OP_BRANCH, 1, W_FET, 4); add(OP_BRANCH, 1, W_DEC, 4); add(OP_BRANCH, 1, W_BR, 4);
        add(OP_JAL, 1, W_FET, 5);    add(OP_JAL, 1, W_DEC, 5);    add(OP_JAL, 1, W_JAL, 5);
        add(OP_JALR, 1, W_FET, 6);   add(OP_JALR, 1, W_DEC, 6);   add(OP_JALR, 1, W_JALR, 6);
        // Illegal opcode: TRAP for 10 cycles regardless of mem_ready.
        add(OP_BAD, 1, W_FET, 7);    add(OP_BAD, 1, W_DEC, 7);
        for (int i = 0; i < 10; i++) add(OP_R, logic'(i % 2), W_TRAP, 7);

        sel = 0;
        do_reset("u0_reset");
        for (int i = 0; i < vecs.size(); i++)
            cyc(vecs[i].op, vecs[i].rdy, vecs[i].exp_ctl, int'(vecs[i].exp_cnt), $sformatf("vec[%0d]", i));
        do_reset("u0_reset_from_trap");
        cyc(OP_R, 1, W_FET, 0, "u0_fetch_after_trap");

        // No-wait unit: store with mem_ready held low completes in 4 cycles, one write strobe.
        rst[0] = 1'b1;
        sel = 1;
        do_reset("u1_reset");
        mw_cycles = 0;
        cyc(OP_STORE, 0, W_FET, 0, "u1_st_fetch"); mw_cycles += int'(ctl_s[10]);
        cyc(OP_STORE, 0, W_DEC, 0, "u1_st_dec");   mw_cycles += int'(ctl_s[10]);
        cyc(OP_STORE, 0, W_MA,  0, "u1_st_addr");  mw_cycles += int'(ctl_s[10]);
        cyc(OP_STORE, 0, W_MWR, 0, "u1_st_wr");    mw_cycles += int'(ctl_s[10]);
        cyc(OP_JALR, 0, W_FET, 1, "u1_st_done");   mw_cycles += int'(ctl_s[10]);
        checks++;
        if (mw_cycles != 1) begin
            errors++;
            $display("FAIL u1_mem_write_cycles: got %0d, expected 1", mw_cycles);
        end
        // jalr disabled: trap and stay there.
        cyc(OP_JALR, 1, W_DEC, 1, "u1_jalr_dec");
        for (int i = 0; i < 10; i++) cyc(OP_JALR, logic'(i % 2), W_TRAP, 1, $sformatf("u1_trap[%0d]", i));
        do_reset("u1_reset_from_trap");
        cyc(OP_R, 0, W_FET, 0, "u1_fetch_after_trap");

        // 4-bit counter: 17 R-type instructions wrap instret to 1.
        rst[1] = 1'b1;
        sel = 2;
        do_reset("u2_reset");
        for (int k = 0; k < 17; k++) begin
            cyc(OP_R, 1, W_FET, k % 16, $sformatf("u2_r%0d_fetch", k));
            cyc(OP_R, 1, W_DEC, k % 16, $sformatf("u2_r%0d_dec", k));
            cyc(OP_R, 1, W_EXR, k % 16, $sformatf("u2_r%0d_exec", k));
            cyc(OP_R, 1, W_WBA, k % 16, $sformatf("u2_r%0d_wb", k));
        end
        cyc(OP_LOAD, 1, W_FET, 1, "u2_wrap_fetch");
        cyc(OP_LOAD, 1, W_DEC, 1, "u2_ld_dec");
        cyc(OP_LOAD, 1, W_MA, 1, "u2_ld_addr");
        cyc(OP_LOAD, 0, W_MRD, 1, "u2_ld_wait");
        // Reset lands in the middle of the memory wait.
        do_reset("u2_reset_mid_wait");
        cyc(OP_R, 1, W_FET, 0, "u2_fetch_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
